key_event_classifier: RTL and testbench

- Sits directly downstream of the key debounce stage; consumes its clean, active-low key level.
- Classifies each key gesture as short press, long press or double click.
- Emits one-cycle event pulses to the application logic (LED or pin drivers).
- Runs on the same 20 MHz clock as the debounce stage, so 1 ms is 20000 cycles.

---
 rtl/key_evt_pkg.sv | 23 ++
 rtl/key_event_classifier_ms_timer.sv | 31 +++
 rtl/key_event_classifier.sv | 129 ++++++++++++
 tb/tb_key_event_classifier.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared states and default timing constants for the key event classifier
package key_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } state_t;

    localparam int CLK_PER_MS_DEF = 20000;
    localparam int LONG_MS_DEF    = 1000;
    localparam int DCLICK_MS_DEF  = 250;
    localparam int REPEAT_MS_DEF  = 100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_classifier_ms_timer.sv
// rtl/key_event_classifier_ms_timer.sv - millisecond prescaler plus saturating ms counter
module ms_timer #(
    parameter int CLK_PER_MS = 20000,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] ms_cnt,
    output logic             ms_tick
);

    localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic [PRE_W-1:0] presc;

    assign ms_tick = (presc == PRE_W'(CLK_PER_MS - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else begin
            presc <= ms_tick ? '0 : presc + 1'b1;
            if (ms_tick && (ms_cnt != '1)) begin
                ms_cnt <= ms_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_classifier.sv
// rtl/key_event_classifier.sv - short/long/double-click classifier; KEY_REPEAT_EN adds auto-repeat in HOLD
module key_event_classifier
    import key_evt_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF,
    parameter int LONG_MS    = LONG_MS_DEF,
    parameter int DCLICK_MS  = DCLICK_MS_DEF,
    parameter int REPEAT_MS  = REPEAT_MS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic evt_short,
    output logic evt_long,
    output logic evt_double,
    output logic evt_repeat,
    output logic busy
);

    localparam int CNT_W = $clog2(max3(LONG_MS, DCLICK_MS, REPEAT_MS) + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] ms_cnt;
    logic             ms_tick;
    logic             clr;
    logic             rep_clr;
    logic             long_hit;
    logic             dclick_hit;
    logic             short_nx;
    logic             long_nx;
    logic             double_nx;
    logic             repeat_nx;

    // A threshold is reached on the edge where the counter steps onto it.
    assign long_hit   = ms_tick && (ms_cnt == CNT_W'(LONG_MS - 1));
    assign dclick_hit = ms_tick && (ms_cnt == CNT_W'(DCLICK_MS - 1));
    assign clr        = (state_next != state) || rep_clr;
    assign busy       = (state != IDLE);

    ms_timer #(
        .CLK_PER_MS(CLK_PER_MS),
        .CNT_W     (CNT_W)
    ) u_ms_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .ms_cnt (ms_cnt),
        .ms_tick(ms_tick)
    );

`ifdef KEY_REPEAT_EN
    logic repeat_hit;
    assign repeat_hit = ms_tick && (ms_cnt == CNT_W'(REPEAT_MS - 1));
`endif

    always_comb begin
        state_next = state;
        short_nx   = 1'b0;
        long_nx    = 1'b0;
        double_nx  = 1'b0;
        repeat_nx  = 1'b0;
        rep_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (!key_n) state_next = PRESS1;
            end
            PRESS1: begin
                if (key_n) begin
                    state_next = WAIT2;
                end else if (long_hit) begin
                    state_next = HOLD;
                    long_nx    = 1'b1;
                end
            end
            WAIT2: begin
                if (!key_n) begin
                    state_next = PRESS2;
                end else if (dclick_hit) begin
                    state_next = IDLE;
                    short_nx   = 1'b1;
                end
            end
            PRESS2: begin
                if (key_n) begin
                    state_next = IDLE;
                    double_nx  = 1'b1;
                end
            end
            HOLD: begin
                if (key_n) begin
                    state_next = IDLE;
`ifdef KEY_REPEAT_EN
                end else if (repeat_hit) begin
                    repeat_nx = 1'b1;
                    rep_clr   = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            evt_short  <= 1'b0;
            evt_long   <= 1'b0;
            evt_double <= 1'b0;
        end else begin
            state      <= state_next;
            evt_short  <= short_nx;
            evt_long   <= long_nx;
            evt_double <= double_nx;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) evt_repeat <= 1'b0;
        else     evt_repeat <= repeat_nx;
    end
`else
    assign evt_repeat = 1'b0;
    logic unused_repeat;
    assign unused_repeat = repeat_nx;
`endif

endmodule

// File: tb/tb_key_event_classifier.sv
// tb/tb_key_event_classifier.sv - directed plus random key waveforms checked against a gesture-level model
module tb_key_event_classifier;

    localparam int CPM   = 20;
    localparam int LMS   = 10;
    localparam int DMS   = 5;
    localparam int RMS   = 3;
    localparam int LC    = LMS * CPM;
    localparam int DCC   = DMS * CPM;
    localparam int RC    = RMS * CPM;
    localparam int MAXT  = 10000;

    logic clk = 1'b0;
    logic rst;
    logic key_n;
    logic evt_short, evt_long, evt_double, evt_repeat, busy;

    always #5 clk = ~clk;

    key_event_classifier #(
        .CLK_PER_MS(CPM),
        .LONG_MS   (LMS),
        .DCLICK_MS (DMS),
        .REPEAT_MS (RMS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .evt_short (evt_short),
        .evt_long  (evt_long),
        .evt_double(evt_double),
        .evt_repeat(evt_repeat),
        .busy      (busy)
    );

    // Per-edge record: inputs sampled at edge t and outputs seen just after it.
    // Output vector bits: {short, long, double, repeat, busy}.
    logic       key_at [MAXT];
    logic       rst_at [MAXT];
    logic [4:0] obs    [MAXT];
    logic [4:0] expv   [MAXT];
    int         t = 0;
    int         checks = 0;
    int         passes = 0;

    task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
        checks++;
        assert (o === e) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, o, e);
    endtask

    task automatic step(input logic k, input logic r);
        key_n = k;
        rst   = r;
        key_at[t] = k;
        rst_at[t] = r;
        @(posedge clk);
        @(negedge clk);
        obs[t] = {evt_short, evt_long, evt_double, evt_repeat, busy};
        t++;
    endtask

    task automatic hold(input logic k, input int n);
        repeat (n) step(k, 1'b0);
    endtask

    function automatic int first_level(input int from, input logic lvl);
        for (int j = from; j < t; j++) if (key_at[j] === lvl) return j;
        return t;
    endfunction

    function automatic int next_rst(input int from);
        for (int j = from; j < t; j++) if (rst_at[j]) return j;
        return t;
    endfunction

    function automatic void put(input int idx, input int b, input int abort_at);
        if (idx < abort_at && idx < t) expv[idx][b] = 1'b1;
    endfunction

    // Gesture-level model: locate press/release runs and apply the timing rules by arithmetic.
    task automatic run_model();
        int i, p, a, r, q, r2, e;
        for (int j = 0; j < t; j++) expv[j] = '0;
        i = 0;
        while (i < t) begin
            if (rst_at[i] || key_at[i]) begin
                i++;
                continue;
            end
            p = i;
            a = next_rst(p + 1);
            r = first_level(p + 1, 1'b1);
            if (r - p > LC) begin
                put(p + LC, 3, a);
`ifdef KEY_REPEAT_EN
                for (int k = p + LC + RC; k < r; k += RC) put(k, 1, a);
`endif
                e = r;
            end else begin
                q = first_level(r + 1, 1'b0);
                if (q - r <= DCC) begin
                    r2 = first_level(q + 1, 1'b1);
                    put(r2, 2, a);
                    e = r2;
                end else begin
                    put(r + DCC, 4, a);
                    e = r + DCC;
                end
            end
            if (a < e) e = a;
            for (int j = p; j < e && j < t; j++) expv[j][0] = 1'b1;
            i = e + 1;
        end
    endtask

    initial begin
        int rs, pl, rd, rg, rd2, tr, nrep, lvl, n;
        key_n = 1'b1;
        rst   = 1'b1;
        @(negedge clk);

        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        hold(1'b1, 5);

        // short press
        hold(1'b0, 60);
        rs = t;
        hold(1'b1, 150);

        // long press
        pl = t;
        hold(1'b0, 400);
        hold(1'b1, 150);

        // double click
        hold(1'b0, 40);
        hold(1'b1, 40);
        hold(1'b0, 40);
        rd = t;
        hold(1'b1, 150);

        // gap boundary: release edge then exactly DCC more high cycles -> timeout wins
        hold(1'b0, 40);
        rg = t;
        hold(1'b1, 1);
        hold(1'b1, DCC);
        hold(1'b0, 40);
        hold(1'b1, 150);

        // gap one shorter: press lands on the timeout edge and wins
        hold(1'b0, 40);
        hold(1'b1, 1);
        hold(1'b1, DCC - 1);
        hold(1'b0, 40);
        rd2 = t;
        hold(1'b1, 150);

        // reset during WAIT2
        hold(1'b0, 40);
        hold(1'b1, 50);
        tr = t;
        step(1'b1, 1'b1);
        hold(1'b1, 150);

        // random gestures, biased toward the timing boundaries
        while (t < 9000) begin
            if ($urandom_range(0, 19) == 0) step($urandom_range(0, 1) == 1, 1'b1);
            lvl = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       n = lvl ? (DCC - 1 + $urandom_range(0, 2)) : (LC - 1 + $urandom_range(0, 2));
                1:       n = lvl ? $urandom_range(1, 160) : $urandom_range(150, 450);
                default: n = $urandom_range(1, 90);
            endcase
            hold(lvl[0], n);
        end
        hold(1'b1, 250);

        run_model();
        for (int j = 0; j < t; j++) begin
            check($sformatf("model@%0d", j), obs[j], expv[j]);
            check($sformatf("onehot@%0d", j), {4'b0, ($countones(obs[j][4:1]) <= 1)}, 5'd1);
        end

        check("reset_state", obs[1], 5'b00000);
        check("short_at_dcc", obs[rs + DCC], 5'b10000);
        check("long_at_lc", obs[pl + LC], 5'b01001);
        check("long_release_idle", obs[pl + 400], 5'b00000);
        check("double_on_release", obs[rd], 5'b00100);
        check("gap_timeout_short", obs[rg + DCC], 5'b10000);
        check("gap_new_press1", {4'b0, obs[rg + DCC + 1][0]}, 5'd1);
        check("gap_minus1_double", obs[rd2], 5'b00100);
        check("reset_mid_wait2", obs[tr], 5'b00000);
        nrep = 0;
        for (int j = pl; j < pl + 400; j++) nrep += int'(obs[j][1]);
`ifdef KEY_REPEAT_EN
        check("repeat_count", 5'(nrep), 5'd3);
        check("repeat_first", obs[pl + LC + RC], 5'b00011);
`else
        check("repeat_count", 5'(nrep), 5'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
